// File: rtl/cache_pkg.sv
// cache_pkg: shared line geometry, line-buffer FSM states and address helpers
package cache_pkg;
   localparam int LINE_W = 256;
   localparam int WORDS  = 8;
   localparam int OFFS_W = 3;
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WB_WRITE  = 3'd1,
      ST_WB_DONE   = 3'd2,
      ST_FILL_READ = 3'd3,
      ST_FILL_DONE = 3'd4
   } state_e;
   // Clears the word-offset bits; addresses up to 64 bits wide are accepted.
   function automatic logic [63:0] line_base(input logic [63:0] addr, input int offs_w);
      return addr & ~((64'd1 << offs_w) - 64'd1);
   endfunction
endpackage

// File: rtl/line_word_seq.sv
// line_word_seq: word counter plus wrapping offset generator for one line transfer
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         restart the sequence at start_i with counter 0
//   advance_i      current word is done, step to the next one
//   start_i        first word offset (critical word for fills, 0 for write-back)
//   cnt_o          words completed so far (one bit wider than the offset)
//   offset_o       word offset of the current word, wraps modulo WORDS
//   last_o         the current word is the final word of the line
module line_word_seq #(
   parameter int WORDS = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       load_i,
   input  logic                       advance_i,
   input  logic [$clog2(WORDS)-1:0]   start_i,
   output logic [$clog2(WORDS):0]     cnt_o,
   output logic [$clog2(WORDS)-1:0]   offset_o,
   output logic                       last_o
);
   localparam int OW = $clog2(WORDS);
   localparam logic [OW:0] ONE = 1;
   logic [OW-1:0] start_q, start_d;
   logic [OW:0]   cnt_q, cnt_d;
   always_comb begin
      start_d = load_i ? start_i : start_q;
      cnt_d   = load_i ? '0 : advance_i ? cnt_q + ONE : cnt_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q <= '0;
         cnt_q   <= '0;
      end else begin
         start_q <= start_d;
         cnt_q   <= cnt_d;
      end
   end
   // Offset arithmetic is OW bits wide, so the wrap to word 0 is free.
   assign offset_o = start_q + cnt_q[OW-1:0];
   assign last_o   = &cnt_q[OW-1:0];
   assign cnt_o    = cnt_q;
endmodule

// File: rtl/dcache_line_buffer.sv
// dcache_line_buffer: memory-side line-fill and victim write-back engine for the data cache
// Ports:
//   Clk, Rst                 clock, asynchronous active-low reset
//   LB_Enable, Miss_Addr     fill request and missing word address
//   LB_FirstWord/CritWord    registered pulse with the critical word
//   LB_Completed             pulse: LB_LineData / LB_LineAddr valid
//   LW_Enable, Victim_Addr   write-back request and victim line address
//   oLineData                victim line, captured when the write-back starts
//   LineWriteBufAddr         line-aligned Miss_Addr for the cache victim read
//   LW_Completed             pulse: every victim word acknowledged
//   Mem_*                    single-word request/acknowledge memory bus
module dcache_line_buffer #(
   parameter int WORDS  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  LB_Enable,
   input  logic [ADDR_W-1:0]     Miss_Addr,
   output logic                  LB_FirstWord,
   output logic [31:0]           LB_CritWord,
   output logic                  LB_Completed,
   output logic [WORDS*32-1:0]   LB_LineData,
   output logic [ADDR_W-1:0]     LB_LineAddr,
   input  logic                  LW_Enable,
   input  logic [ADDR_W-1:0]     Victim_Addr,
   input  logic [WORDS*32-1:0]   oLineData,
   output logic [ADDR_W-1:0]     LineWriteBufAddr,
   output logic                  LW_Completed,
   output logic                  Mem_Req,
   output logic                  Mem_RW,
   output logic [ADDR_W-1:0]     Mem_Addr,
   output logic [31:0]           Mem_WData,
   input  logic [31:0]           Mem_RData,
   input  logic                  Mem_Ack
);
   import cache_pkg::*;
   localparam int OW = $clog2(WORDS);
   localparam int LW = WORDS * 32;
   state_e            state_q, state_d;
   logic [LW-1:0]     victim_q, victim_d, line_q, line_d;
   logic [ADDR_W-1:0] vaddr_q, vaddr_d, laddr_q, laddr_d;
   logic [31:0]       crit_q, crit_d;
   logic              first_q, first_d;
   logic              seq_load, seq_adv, seq_last;
   logic [OW-1:0]     seq_start, seq_off;
   logic [OW:0]       seq_cnt;
   logic [ADDR_W-1:0] miss_base;
   assign miss_base = ADDR_W'(line_base(64'(Miss_Addr), OW));
   line_word_seq #(.WORDS(WORDS)) u_seq (
      .clk_i     (Clk),
      .rst_ni    (Rst),
      .load_i    (seq_load),
      .advance_i (seq_adv),
      .start_i   (seq_start),
      .cnt_o     (seq_cnt),
      .offset_o  (seq_off),
      .last_o    (seq_last)
   );
   // Mem_Ack only counts while a word is actually requested.
   assign seq_adv = Mem_Ack && (state_q == ST_WB_WRITE || state_q == ST_FILL_READ);
   always_comb begin
      state_d   = state_q;
      victim_d  = victim_q;
      vaddr_d   = vaddr_q;
      laddr_d   = laddr_q;
      line_d    = line_q;
      crit_d    = crit_q;
      first_d   = 1'b0;
      seq_load  = 1'b0;
      seq_start = '0;
      case (state_q)
         ST_IDLE: begin
            // Write-back wins a tie; a held LB_Enable is served on a later IDLE.
            if (LW_Enable) begin
               victim_d = oLineData;
               vaddr_d  = Victim_Addr;
               seq_load = 1'b1;
               state_d  = ST_WB_WRITE;
            end else if (LB_Enable) begin
               laddr_d   = miss_base;
               seq_start = Miss_Addr[OW-1:0];
               seq_load  = 1'b1;
               state_d   = ST_FILL_READ;
            end
         end
         ST_WB_WRITE:  state_d = (seq_adv && seq_last) ? ST_WB_DONE : ST_WB_WRITE;
         ST_FILL_READ: begin
            if (seq_adv) begin
               line_d[seq_off*32 +: 32] = Mem_RData;
               if (seq_cnt == '0) begin
                  crit_d  = Mem_RData;
                  first_d = 1'b1;
               end
               if (seq_last) state_d = ST_FILL_DONE;
            end
         end
         default:      state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q  <= ST_IDLE;
         victim_q <= '0;
         vaddr_q  <= '0;
         laddr_q  <= '0;
         line_q   <= '0;
         crit_q   <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         vaddr_q  <= vaddr_d;
         laddr_q  <= laddr_d;
         line_q   <= line_d;
         crit_q   <= crit_d;
         first_q  <= first_d;
      end
   end
   assign Mem_Req          = state_q == ST_WB_WRITE || state_q == ST_FILL_READ;
   assign Mem_RW           = state_q == ST_WB_WRITE;
   assign Mem_Addr         = !Mem_Req ? '0 : (Mem_RW ? vaddr_q : laddr_q) | ADDR_W'(seq_off);
   assign Mem_WData        = Mem_RW ? victim_q[seq_off*32 +: 32] : '0;
   assign LW_Completed     = state_q == ST_WB_DONE;
   assign LB_Completed     = state_q == ST_FILL_DONE;
   assign LB_FirstWord     = first_q;
   assign LB_CritWord      = crit_q;
   assign LB_LineData      = line_q;
   assign LB_LineAddr      = laddr_q;
   assign LineWriteBufAddr = miss_base;
endmodule

// File: tb/tb_dcache_line_buffer.sv
// tb_dcache_line_buffer: directed self-checking bench for the line buffer
module tb_dcache_line_buffer;
   localparam logic [31:0] K = 32'h5A5A_0000;
   logic         Clk = 1'b0;
   logic         Rst, LB_Enable, LW_Enable, Mem_Ack;
   logic [31:0]  Miss_Addr, Victim_Addr, Mem_RData;
   logic [255:0] oLineData;
   logic         LB_FirstWord, LB_Completed, LW_Completed, Mem_Req, Mem_RW;
   logic [31:0]  LB_CritWord, LB_LineAddr, LineWriteBufAddr, Mem_Addr, Mem_WData;
   logic [255:0] LB_LineData;
   int checks = 0, errors = 0, cyc = 0, lat = 3;
   bit zero_wait = 1'b0;
   logic [31:0] q_addr[$], q_wd[$];
   bit          q_rw[$];
   int n_first = 0, n_lbc = 0, n_lwc = 0, lbc_cyc = 0, lwc_cyc = 0;
   logic [31:0] crit_seen = '0;
   always #5 Clk = ~Clk;
   dcache_line_buffer dut (
      .Clk(Clk), .Rst(Rst),
      .LB_Enable(LB_Enable), .Miss_Addr(Miss_Addr),
      .LB_FirstWord(LB_FirstWord), .LB_CritWord(LB_CritWord),
      .LB_Completed(LB_Completed), .LB_LineData(LB_LineData), .LB_LineAddr(LB_LineAddr),
      .LW_Enable(LW_Enable), .Victim_Addr(Victim_Addr), .oLineData(oLineData),
      .LineWriteBufAddr(LineWriteBufAddr), .LW_Completed(LW_Completed),
      .Mem_Req(Mem_Req), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
      .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
   );
   // memory model: read data is a fixed function of the word address
   assign Mem_RData = Mem_Addr ^ K;
   always @(posedge Clk) cyc++;
   always @(negedge Clk) begin
      if (Mem_Req && Mem_Ack) begin
         q_addr.push_back(Mem_Addr);
         q_wd.push_back(Mem_WData);
         q_rw.push_back(Mem_RW);
      end
      if (LB_FirstWord) begin
         n_first++;
         crit_seen = LB_CritWord;
      end
      if (LB_Completed) begin
         n_lbc++;
         lbc_cyc = cyc;
      end
      if (LW_Completed) begin
         n_lwc++;
         lwc_cyc = cyc;
      end
   end
   initial begin
      int w = 0;
      Mem_Ack = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         if (zero_wait) Mem_Ack = 1'b1;
         else if (Mem_Req && !Mem_Ack) begin
            w++;
            Mem_Ack = w >= lat;
            if (Mem_Ack) w = 0;
         end else begin
            Mem_Ack = 1'b0;
            w = 0;
         end
      end
   end
   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask
   task automatic wait_done(input bit lb, input string tag);
      int t = 0;
      do begin
         @(negedge Clk);
         t++;
      end while (!(lb ? LB_Completed : LW_Completed) && t < 500);
      chk(tag, 256'(t < 500), 256'(1));
      @(posedge Clk);
      #1;
      if (lb) LB_Enable = 1'b0;
      else LW_Enable = 1'b0;
   endtask
   task automatic check_fill(input logic [31:0] a, input int base, input int f0, input int c0);
      logic [31:0]  lb;
      logic [255:0] line;
      lb = a & ~32'd7;
      chk("fill_words", 256'(q_addr.size() - base), 256'(8));
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ea;
         ea = lb | ((a + 32'(i)) & 32'd7);
         line[ea[2:0]*32 +: 32] = ea ^ K;
         if (base + i < q_addr.size()) begin
            chk("rd_addr", 256'(q_addr[base+i]), 256'(ea));
            chk("rd_rw", 256'(q_rw[base+i]), 256'(0));
         end
      end
      chk("first_cnt", 256'(n_first - f0), 256'(1));
      chk("crit_word", 256'(crit_seen), 256'(a ^ K));
      chk("lbc_cnt", 256'(n_lbc - c0), 256'(1));
      chk("line_addr", 256'(LB_LineAddr), 256'(lb));
      chk("line_data", LB_LineData, line);
   endtask
   task automatic run_fill(input logic [31:0] a);
      int base, f0, c0;
      base = q_addr.size();
      f0 = n_first;
      c0 = n_lbc;
      @(posedge Clk);
      #1;
      Miss_Addr = a;
      LB_Enable = 1'b1;
      wait_done(1'b1, "fill_timeout");
      check_fill(a, base, f0, c0);
   endtask
   task automatic load_victim(input logic [31:0] va, input logic [31:0] d0);
      Victim_Addr = va;
      for (int i = 0; i < 8; i++) oLineData[i*32 +: 32] = d0 + 32'(i);
   endtask
   task automatic check_wb(input logic [31:0] va, input logic [31:0] d0, input int base);
      for (int i = 0; i < 8; i++) begin
         if (base + i < q_addr.size()) begin
            chk("wr_addr", 256'(q_addr[base+i]), 256'(va | 32'(i)));
            chk("wr_data", 256'(q_wd[base+i]), 256'(d0 + 32'(i)));
            chk("wr_rw", 256'(q_rw[base+i]), 256'(1));
         end else chk("wr_missing", 256'(q_addr.size()), 256'(base + 8));
      end
   endtask
   initial begin
      int base, f0, c0, w0, n, t;
      Rst = 1'b0;
      LB_Enable = 1'b0;
      LW_Enable = 1'b0;
      Miss_Addr = '0;
      Victim_Addr = '0;
      oLineData = '0;
      repeat (3) @(negedge Clk);
      chk("rst_req", 256'(Mem_Req), 256'(0));
      chk("rst_addr", 256'(Mem_Addr), 256'(0));
      chk("rst_wdata", 256'(Mem_WData), 256'(0));
      chk("rst_line", LB_LineData, 256'(0));
      chk("rst_laddr", 256'(LB_LineAddr), 256'(0));
      chk("rst_crit", 256'(LB_CritWord), 256'(0));
      chk("rst_pulses", 256'({LB_FirstWord, LB_Completed, LW_Completed}), 256'(0));
      @(posedge Clk);
      #1;
      Rst = 1'b1;
      // 1: critical-word-first fill with waited acks
      Miss_Addr = 32'h105;
      #1;
      chk("wbuf_addr", 256'(LineWriteBufAddr), 256'(32'h100));
      run_fill(32'h105);
      // 2: plain write-back
      base = q_addr.size();
      w0 = n_lwc;
      @(posedge Clk);
      #1;
      load_victim(32'h200, 32'hA0);
      LW_Enable = 1'b1;
      wait_done(1'b0, "wb_timeout");
      chk("wb_words", 256'(q_addr.size() - base), 256'(8));
      check_wb(32'h200, 32'hA0, base);
      chk("lwc_cnt", 256'(n_lwc - w0), 256'(1));
      // 3: both requests together, write-back goes first
      base = q_addr.size();
      w0 = n_lwc;
      f0 = n_first;
      c0 = n_lbc;
      @(posedge Clk);
      #1;
      load_victim(32'h300, 32'hB0);
      Miss_Addr = 32'h2A2;
      LW_Enable = 1'b1;
      LB_Enable = 1'b1;
      wait_done(1'b0, "both_wb_timeout");
      wait_done(1'b1, "both_fill_timeout");
      chk("both_words", 256'(q_addr.size() - base), 256'(16));
      check_wb(32'h300, 32'hB0, base);
      check_fill(32'h2A2, base + 8, f0, c0);
      chk("lwc_before_lbc", 256'(lwc_cyc < lbc_cyc), 256'(1));
      chk("both_lwc_cnt", 256'(n_lwc - w0), 256'(1));
      // 4: zero-wait memory, minimum fill latency
      zero_wait = 1'b1;
      base = q_addr.size();
      f0 = n_first;
      c0 = n_lbc;
      @(posedge Clk);
      #1;
      Miss_Addr = 32'h33;
      LB_Enable = 1'b1;
      t = 0;
      do begin
         @(negedge Clk);
         t++;
      end while (!Mem_Req && t < 50);
      n = 1;
      while (!LB_Completed && n < 50) begin
         @(negedge Clk);
         n++;
      end
      @(posedge Clk);
      #1;
      LB_Enable = 1'b0;
      zero_wait = 1'b0;
      chk("zw_latency", 256'(n), 256'(9));
      @(posedge Clk);
      #1;
      check_fill(32'h33, base, f0, c0);
      // 6: offset corners
      run_fill(32'h40);
      run_fill(32'h47);
      // 5: async reset in the middle of a fill
      base = q_addr.size();
      @(posedge Clk);
      #1;
      Miss_Addr = 32'h0;
      LB_Enable = 1'b1;
      t = 0;
      while (q_addr.size() - base < 3 && t < 200) begin
         @(negedge Clk);
         t++;
      end
      chk("mid_fill_reached", 256'(q_addr.size() - base >= 3), 256'(1));
      #2;
      Rst = 1'b0;
      #1;
      chk("arst_req", 256'(Mem_Req), 256'(0));
      chk("arst_addr", 256'(Mem_Addr), 256'(0));
      chk("arst_line", LB_LineData, 256'(0));
      chk("arst_crit", 256'(LB_CritWord), 256'(0));
      chk("arst_laddr", 256'(LB_LineAddr), 256'(0));
      chk("arst_pulses", 256'({LB_FirstWord, LB_Completed, LW_Completed}), 256'(0));
      LB_Enable = 1'b0;
      @(posedge Clk);
      #1;
      Rst = 1'b1;
      run_fill(32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
